// File: rtl/mips_pkg.sv
// Shared fetch-stage types: FSM states, next-PC select encodings and the NOP word.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [1:0]  PCSRC_SEQ    = 2'b00;
  localparam logic [1:0]  PCSRC_JUMP   = 2'b01;
  localparam logic [1:0]  PCSRC_BRANCH = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Word-align a redirect target.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, stall holds, otherwise load or bubble.
// Latency 1 cycle; stall freezes contents, flush wins over stall.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= NOP;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (stall) begin
      instr <= instr;
      pc4   <= pc4;
      valid <= valid;
    end else if (load) begin
      instr <= new_instr;
      pc4   <= new_pc4;
      valid <= 1'b1;
    end else begin
      // Nothing real to hand on this cycle.
      instr <= NOP;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, fetch FSM and skid buffer feeding the IF/ID register.
// Zero-latency ack sustains one instr/cycle; stall parks a returned word in the skid buffer.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] BranchAddr,
  input  logic        IF_ID_Stall,
  input  logic        IF_ID_Flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_IF_ID,
  output logic [31:0] PC4_IF_ID,
  output logic        Valid_IF_ID
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  skid_instr, skid_instr_nxt;
  logic [31:0]  skid_pc4, skid_pc4_nxt;
  logic [31:0]  saved_tgt, saved_tgt_nxt;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         load;
  logic [31:0]  new_instr;
  logic [31:0]  new_pc4;

  assign redirect  = (PCSrc == PCSRC_JUMP) || (PCSrc == PCSRC_BRANCH);
  assign target    = align_word((PCSrc == PCSRC_JUMP) ? JumpAddr : BranchAddr);
  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    skid_instr_nxt = skid_instr;
    skid_pc4_nxt   = skid_pc4;
    saved_tgt_nxt  = saved_tgt;
    load           = 1'b0;
    new_instr      = imem_rdata;
    new_pc4        = pc_plus4;
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt = target;
          end else begin
            pc_nxt = pc_plus4;
            if (IF_ID_Stall) begin
              skid_instr_nxt = imem_rdata;
              skid_pc4_nxt   = pc_plus4;
              state_nxt      = HOLD;
            end else begin
              load = 1'b1;
            end
          end
        end else if (redirect) begin
          // Outstanding request cannot be withdrawn; wait it out first.
          saved_tgt_nxt = target;
          state_nxt     = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (!IF_ID_Stall) begin
          load      = 1'b1;
          new_instr = skid_instr;
          new_pc4   = skid_pc4;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) saved_tgt_nxt = target;
        if (imem_ack) begin
          pc_nxt    = redirect ? target : saved_tgt;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      skid_instr <= 32'h0;
      skid_pc4   <= 32'h0;
      saved_tgt  <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc4   <= skid_pc4_nxt;
      saved_tgt  <= saved_tgt_nxt;
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (IF_ID_Flush),
    .stall     (IF_ID_Stall),
    .load      (load),
    .new_instr (new_instr),
    .new_pc4   (new_pc4),
    .instr     (Instr_IF_ID),
    .pc4       (PC4_IF_ID),
    .valid     (Valid_IF_ID)
  );

endmodule
